// File: rtl/conv_add_tree.sv
// conv_add_tree: 25-product adder tree feeding a per-group channel accumulator with bias and saturation
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   prod_i      : 25 packed signed products, element k at [k*IN_W +: IN_W]
//   in_valid    : prod_i holds one channel's products this cycle
//   bias_i      : signed bias, sampled when a group's first channel leaves the tree
//   clear       : synchronous abort of all in-flight work
//   sum_o       : registered saturated group result, held between pulses
//   sum_valid_o : one-cycle pulse qualifying sum_o
//   busy_o      : data in flight, group open, or output pulse pending
//   ch_cnt_o    : index of the next channel the accumulator expects
module conv_add_tree #(
    parameter int IN_W   = 32,
    parameter int OUT_W  = 32,
    parameter int NUM_CH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [25*IN_W-1:0]    prod_i,
    input  logic                  in_valid,
    input  logic [OUT_W-1:0]      bias_i,
    input  logic                  clear,
    output logic [OUT_W-1:0]      sum_o,
    output logic                  sum_valid_o,
    output logic                  busy_o,
    output logic [7:0]            ch_cnt_o
);
    localparam int ACC_W = IN_W + 13;

    typedef enum logic {IDLE, ACC} state_t;

    state_t                   state;
    logic [4:0]               vld;
    logic [7:0]               ch_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  s0 [25];
    logic signed [ACC_W-1:0]  s1 [13];
    logic signed [ACC_W-1:0]  s2 [7];
    logic signed [ACC_W-1:0]  s3 [4];
    logic signed [ACC_W-1:0]  s4 [2];
    logic signed [ACC_W-1:0]  s5;
    logic signed [ACC_W-1:0]  nxt;
    logic [ACC_W-OUT_W:0]     hi;
    logic                     last;
    logic                     fits;
    logic [OUT_W-1:0]         sat;

    always_comb begin
        for (int k = 0; k < 25; k++) s0[k] = ACC_W'($signed(prod_i[k*IN_W +: IN_W]));
    end

    // Tree data is unreset; only the valid pipeline qualifies it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 12; i++) s1[i] <= s0[2*i] + s0[2*i+1];
        s1[12] <= s0[24];
        for (int i = 0; i < 6; i++) s2[i] <= s1[2*i] + s1[2*i+1];
        s2[6] <= s1[12];
        for (int i = 0; i < 3; i++) s3[i] <= s2[2*i] + s2[2*i+1];
        s3[3] <= s2[6];
        for (int i = 0; i < 2; i++) s4[i] <= s3[2*i] + s3[2*i+1];
        s5 <= s4[0] + s4[1];
    end

    // First channel of a group starts from the bias, later ones from the accumulator.
    assign nxt  = (state == IDLE ? ACC_W'($signed(bias_i)) : acc) + s5;
    assign last = ch_cnt == 8'(NUM_CH - 1);
    // The value fits OUT_W when all bits from OUT_W-1 upward agree with the sign.
    assign hi   = nxt[ACC_W-1:OUT_W-1];
    assign fits = (&hi) | ~(|hi);
    assign sat  = fits ? nxt[OUT_W-1:0]
                : nxt[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            vld         <= '0;
            ch_cnt      <= '0;
            acc         <= '0;
            sum_o       <= '0;
            sum_valid_o <= 1'b0;
        end else if (clear) begin
            state       <= IDLE;
            vld         <= '0;
            ch_cnt      <= '0;
            acc         <= '0;
            sum_valid_o <= 1'b0;
        end else begin
            vld         <= {vld[3:0], in_valid};
            sum_valid_o <= 1'b0;
            if (vld[4]) begin
                acc <= nxt;
                if (last) begin
                    sum_o       <= sat;
                    sum_valid_o <= 1'b1;
                    ch_cnt      <= '0;
                    state       <= IDLE;
                end else begin
                    ch_cnt <= ch_cnt + 8'd1;
                    state  <= ACC;
                end
            end
        end
    end

    assign busy_o   = (|vld) | (ch_cnt != 8'd0) | sum_valid_o;
    assign ch_cnt_o = ch_cnt;
endmodule

// File: tb/tb_conv_add_tree.sv
// tb_conv_add_tree: scoreboard bench for conv_add_tree with directed groups
module tb_conv_add_tree;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [25*32-1:0]  prod_i = '0;
    logic              in_valid = 1'b0;
    logic [31:0]       bias_i = '0;
    logic              clear = 1'b0;
    logic [31:0]       sum_o;
    logic              sum_valid_o;
    logic              busy_o;
    logic [7:0]        ch_cnt_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] exp_q [$];
    int          cyc_q [$];

    conv_add_tree #(.IN_W(32), .OUT_W(32), .NUM_CH(6)) dut (
        .clk(clk), .rst_n(rst_n), .prod_i(prod_i), .in_valid(in_valid),
        .bias_i(bias_i), .clear(clear), .sum_o(sum_o), .sum_valid_o(sum_valid_o),
        .busy_o(busy_o), .ch_cnt_o(ch_cnt_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    // Monitor: every output pulse pops one expected result and its due cycle.
    always @(negedge clk) begin
        if (rst_n && sum_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got sum_o=%0d expected no pulse", $signed(sum_o));
            end else begin
                check("sum_o", sum_o, exp_q.pop_front());
                check("latency_cycle", 32'(cyc), 32'(cyc_q.pop_front()));
            end
        end
    end

    task automatic drive(input logic [31:0] p0, input logic [31:0] pr);
        for (int k = 0; k < 25; k++) prod_i[k*32 +: 32] = (k == 0) ? p0 : pr;
        in_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // One group of 6 channels; the result is expected 6 cycles after the last channel.
    task automatic group(input logic [31:0] p0, input logic [31:0] pr, input logic [31:0] b,
                         input int gap, input logic [31:0] exp);
        for (int c = 0; c < 6; c++) begin
            if (c == 0) bias_i = b;
            if (c == 5) begin
                exp_q.push_back(exp);
                cyc_q.push_back(cyc + 6);
            end
            drive(p0, pr);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
            exp_q.delete();
            cyc_q.delete();
        end
        idle(4);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_sum_o", sum_o, 0);
        check("reset_sum_valid", 32'(sum_valid_o), 0);
        check("reset_busy", 32'(busy_o), 0);
        check("reset_ch_cnt", 32'(ch_cnt_o), 0);
        rst_n = 1'b1;
        idle(2);

        group(32'd1, 32'd1, 32'd10, 0, 32'd160);
        drain();
        check("hold_sum_o", sum_o, 32'd160);
        check("idle_busy", 32'(busy_o), 0);

        group(-32'sd1000, 32'd0, 32'd0, 2, -32'sd6000);
        drain();

        group(32'h4000_0000, 32'h4000_0000, 32'd0, 0, 32'h7FFF_FFFF);
        drain();
        group(32'hC000_0000, 32'hC000_0000, 32'd0, 0, 32'h8000_0000);
        drain();

        group(32'd1, 32'd1, 32'd10, 0, 32'd160);
        group(32'd2, 32'd2, -32'sd5, 0, 32'd295);
        drain();

        // Clear with three channels accumulated, plus an in_valid in the clear cycle.
        bias_i = 32'd0;
        for (int c = 0; c < 3; c++) drive(32'd1, 32'd1);
        idle(6);
        check("ch_cnt_before_clear", 32'(ch_cnt_o), 3);
        clear = 1'b1;
        drive(32'd1, 32'd1);
        clear = 1'b0;
        in_valid = 1'b0;
        check("ch_cnt_after_clear", 32'(ch_cnt_o), 0);
        check("busy_after_clear", 32'(busy_o), 0);
        idle(8);
        group(32'd1, 32'd1, 32'd0, 0, 32'd150);
        drain();

        // Asynchronous reset in the middle of a group.
        bias_i = 32'd7;
        for (int c = 0; c < 3; c++) drive(32'd5, 32'd5);
        idle(5);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_sum_o", sum_o, 0);
        check("async_rst_busy", 32'(busy_o), 0);
        check("async_rst_ch_cnt", 32'(ch_cnt_o), 0);
        check("async_rst_sum_valid", 32'(sum_valid_o), 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        group(32'd1, 32'd1, 32'd10, 0, 32'd160);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_add_tree.md
CONV_ADD_TREE -- requirements
Module: conv_add_tree

Interface
REQ-001 SHALL have parameter IN_W, default 32, meaning the signed width of each product.
REQ-002 SHALL have parameter OUT_W, default 32, meaning the signed result width.
REQ-003 SHALL have parameter NUM_CH, default 6, meaning input channels accumulated per result (1..255).
REQ-004 SHALL have internal fixed width ACC_W = IN_W+13 for all tree and accumulator arithmetic.
REQ-005 SHALL have port clk, input, 1, clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port prod_i, input, 25*IN_W, packed signed products, element k at bits [k*IN_W +: IN_W], k=0..24.
REQ-008 SHALL have port in_valid, input, 1, prod_i holds one channel's 25 products this cycle.
REQ-009 SHALL have port bias_i, input, OUT_W, signed bias for the current group.
REQ-010 SHALL have port clear, input, 1, synchronous abort of all in-flight work.
REQ-011 SHALL have port sum_o, output, OUT_W, signed saturated result, registered.
REQ-012 SHALL have port sum_valid_o, output, 1, one-cycle pulse qualifying sum_o.
REQ-013 SHALL have port busy_o, output, 1, high while any data is in flight or a group is open.
REQ-014 SHALL have port ch_cnt_o, output, 8, index of the next channel the accumulator expects.

Function
REQ-015 SHALL sign-extend every product to ACC_W before any addition.
REQ-016 SHALL reduce the 25 products in a 5-stage registered tree (25->13->7->4->2->1): each stage adds adjacent pairs, and an odd leftover element passes through registered.
REQ-017 SHALL carry a 5-deep valid shift register alongside the tree; tree_valid = in_valid delayed 5 cycles.
REQ-018 SHALL accept in_valid every cycle with no backpressure; gaps of any length are allowed between channels.
REQ-019 SHALL run an accumulator FSM with states IDLE (ch_cnt=0) and ACC (ch_cnt>0).
REQ-020 SHALL, on tree_valid in IDLE, load acc = sign-extended bias_i + tree_sum, sampling bias_i in that cycle, and go to ACC with ch_cnt=1.
REQ-021 SHALL, on tree_valid in ACC, load acc = acc + tree_sum and increment ch_cnt.
REQ-022 SHALL, on tree_valid when ch_cnt = NUM_CH-1 (for NUM_CH=1, the IDLE cycle), register the saturated final value into sum_o, pulse sum_valid_o the next cycle, and return to IDLE.
REQ-023 SHALL saturate the final value to the range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-024 SHALL hold sum_o between pulses.
REQ-025 SHALL have a latency of 6 cycles from the last channel's in_valid to sum_valid_o.
REQ-026 SHALL allow back-to-back groups: the next group's first tree_valid directly follows the final one with no bubble.
REQ-027 SHALL, on clear, zero the valid pipeline, ch_cnt, and acc, go to IDLE, and force sum_valid_o=0 on the next cycle; clear takes priority over an in_valid in the same cycle, which is dropped; sum_o is held.
REQ-028 SHALL have tree data registers that are not required to be cleared; only valids gate results.
REQ-029 SHALL drive busy_o = OR of the valid pipeline | (ch_cnt != 0) | a pending output pulse.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously drive sum_o=0, sum_valid_o=0, busy_o=0, ch_cnt_o=0, all valid stages=0, acc=0, and FSM=IDLE.
REQ-031 SHALL, on reset deassertion mid-operation, discard all in-flight work; the first in_valid after reset starts a new group.

Verification (IN_W=32, OUT_W=32, NUM_CH=6)
REQ-032 SHALL cover reset: assert rst_n=0 mid-group -> all outputs 0 immediately; a full group afterwards yields the correct value.
REQ-033 SHALL cover a single group: all products=1, bias=10, 6 consecutive in_valid -> sum_o=160, one pulse 6 cycles after the 6th in_valid.
REQ-034 SHALL cover sign: product[0]=-1000, others 0, bias=0, 6 channels with 2-cycle gaps -> sum_o=-6000.
REQ-035 SHALL cover saturation: all products=2^30, bias=0 -> sum_o=0x7FFFFFFF; all products=-2^30 -> 0x80000000.
REQ-036 SHALL cover back-to-back groups: 12 consecutive in_valid, group A all 1 bias 10, group B all 2 bias -5 -> pulses 160 then 295, exactly 6 cycles apart.
REQ-037 SHALL cover clear: clear after 3 channels, then a full group (all 1, bias 0) -> exactly one pulse, sum_o=150, and ch_cnt_o=0 the cycle after clear.
